ssm_tile_gather: RTL and testbench
==================================

Name: ssm_tile_gather

Overview:
- Parametrised successor to the single-head, fixed 8-tile hC collector in the SSM block top.
- Gathers N_TILE-lane hC tiles for up to CH interleaved heads/channels into per-channel ping-pong group buffers. The group length (1..MAX_TILES tiles) is set at runtime.
- Completed groups are emitted in completion order, together with the channel's latched xD, over a valid/ready interface to the adder tree / y_out stage.
- Backpressure reaches the tile stream only when a channel has both banks full.

Parameters:
- DW, 16, element width (FP16 bit pattern, passed through untouched).
- N_TILE, 16, lanes per tile.
- MAX_TILES, 8, maximum tiles per group; output bus width is MAX_TILES*N_TILE*DW.
- CH, 4, number of channels (heads); must be at least 1.
- CH_W, max(1,$clog2(CH)), channel-id width.
- CNT_W, $clog2(MAX_TILES+1), tile-count width.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- cfg_tiles_i  in  CNT_W  tiles per group; sampled per channel when that channel's group starts.
- tile_valid_i  in  1  tile present.
- tile_ready_o  out  1  tile accepted when valid and ready are both high.
- tile_ch_i  in  CH_W  channel of the tile.
- tile_data_i  in  N_TILE*DW  hC tile.
- xD_i  in  DW  x*D for the channel; latched only on the first tile of a group.
- grp_valid_o  out  1  completed group available.
- grp_ready_i  in  1  downstream accepts.
- grp_ch_o  out  CH_W  channel of the group.
- grp_data_o  out  MAX_TILES*N_TILE*DW  tile k occupies bits [(k+1)*N_TILE*DW-1 : k*N_TILE*DW].
- grp_xD_o  out  DW  latched xD.
- grp_ntiles_o  out  CNT_W  tile count of the group.
- cfg_err_o  out  1  sticky: an illegal cfg_tiles_i was sampled.

Behaviour:
- Reset values:
  - tile_ready_o=1, grp_valid_o=0, grp_ch_o=0, grp_data_o=0, grp_xD_o=0, grp_ntiles_o=0, cfg_err_o=0.
  - All banks empty, all write pointers 0, order FIFO empty.
- Reset asserted mid-operation: all partial and completed groups are discarded, with no emission.
- Per-channel state:
  - Write-bank select wb, tile pointer ptr (0..MAX_TILES-1), group length len, xD latch.
  - Two banks, each with a full flag.
- Start of a group (accept with ptr==0):
  - Sample len=cfg_tiles_i.
  - If cfg_tiles_i is 0 or greater than MAX_TILES: clamp len to MAX_TILES and set cfg_err_o. cfg_err_o is cleared only by reset.
  - Latch xD_i.
  - Zero bank slots len..MAX_TILES-1.
- Every accept writes tile_data_i into slot ptr of bank wb for channel tile_ch_i.
  - If ptr==len-1: mark the bank full, push {ch,bank} into the order FIFO (depth 2*CH), set ptr=0 and toggle wb.
  - Otherwise ptr increments.
- A cfg_tiles_i change mid-group has no effect until that channel's next group.
- tile_ready_o = !full[tile_ch_i][wb[tile_ch_i]]. This is combinational on tile_ch_i; other channels are never blocked.
- Output side:
  - grp_valid_o = FIFO not empty.
  - grp_ch_o, grp_data_o, grp_xD_o and grp_ntiles_o reflect the FIFO-head bank, driven from registers or the bank mux.
  - The outputs stay stable while grp_valid_o && !grp_ready_i.
  - On handshake: pop the FIFO and clear that bank's full flag. The bank is writable from the next cycle.
- Latency: a group-completing tile accepted at edge t gives grp_valid_o=1 after edge t (visible in cycle t+1), provided the FIFO was empty.
- Simultaneous completion and handshake in the same cycle: push and pop both occur, and FIFO order is preserved.
- A completion push never overflows, since at most 2*CH banks can be full.
- Order of emission is strictly completion order, across channels and banks.
- grp_ready_i held high with a continuous tile stream: throughput is one tile per cycle with no bubbles (II=1).

Test Plan:
- CH=1, cfg_tiles=8: 8 tiles with lane0 values 0x3C00..0x4800, xD_i=0x3800 on tile0 and 0xFFFF on the others. Required: grp_valid_o one cycle after tile 7; grp_ntiles_o=8; slot k lane0 matches the input; grp_xD_o=0x3800.
- cfg_tiles=3: 3 tiles, then cfg changed to 5 on tile 1. Required: group of 3; slots 3..7 all zero; the next group has length 5.
- grp_ready_i=0, channel 2, three groups of 2 tiles. Required: tile_ready_o falls to 0 on the 5th tile attempt. Channel 0 tiles are still accepted in that cycle. After one handshake, ready returns the next cycle.
- Interleave: ch1 tile, ch0 tile, ch1 tile (ch1 completes), ch0 tile (ch0 completes), cfg=2. Required: emission order ch1 then ch0; outputs stable over 4 stall cycles.
- cfg_tiles=0, then 9 with MAX_TILES=8. Required: cfg_err_o=1 from the first bad sample onward; both groups have grp_ntiles_o=8.
- Reset pulse after 5 of 8 tiles, with one completed group pending. Required: all outputs go to their reset values immediately; the next 8 tiles form a clean group with no stale data.

Source files
------------

// File: rtl/ssm_tile_gather.sv
// rtl/ssm_tile_gather.sv - per-channel ping-pong hC tile gatherer with completion-ordered group output
//
// Collects N_TILE-lane hC tiles for CH interleaved channels into two group
// banks per channel. Finished groups are emitted in completion order with the
// xD latched at their first tile.
// Ports:
//   clk, rstn      clock, asynchronous active-low reset
//   cfg_tiles_i    tiles per group, sampled when a channel starts a group
//   tile_*         tile stream: valid/ready, channel id, data, xD
//   grp_*          group stream: valid/ready, channel, data, xD, tile count
//   cfg_err_o      sticky flag, an illegal cfg_tiles_i was sampled
module ssm_tile_gather #(
  parameter int DW        = 16,
  parameter int N_TILE    = 16,
  parameter int MAX_TILES = 8,
  parameter int CH        = 4,
  parameter int CH_W      = (CH > 1) ? $clog2(CH) : 1,
  parameter int CNT_W     = $clog2(MAX_TILES + 1)
) (
  input  logic                           clk,
  input  logic                           rstn,
  input  logic [CNT_W-1:0]               cfg_tiles_i,
  input  logic                           tile_valid_i,
  output logic                           tile_ready_o,
  input  logic [CH_W-1:0]                tile_ch_i,
  input  logic [N_TILE*DW-1:0]           tile_data_i,
  input  logic [DW-1:0]                  xD_i,
  output logic                           grp_valid_o,
  input  logic                           grp_ready_i,
  output logic [CH_W-1:0]                grp_ch_o,
  output logic [MAX_TILES*N_TILE*DW-1:0] grp_data_o,
  output logic [DW-1:0]                  grp_xD_o,
  output logic [CNT_W-1:0]               grp_ntiles_o,
  output logic                           cfg_err_o
);

  localparam int TW    = N_TILE * DW;
  localparam int PTR_W = (MAX_TILES > 1) ? $clog2(MAX_TILES) : 1;
  localparam int FD    = 2 * CH;
  localparam int FP_W  = $clog2(FD);
  localparam int FC_W  = $clog2(FD + 1);

  // Bank storage has no reset: a new group always rewrites slot 0..len-1 and
  // zeroes the rest, and the outputs are gated while nothing is pending.
  logic [TW-1:0]    mem_q  [CH][2][MAX_TILES];
  logic [1:0]       full_q [CH];
  logic [CH-1:0]    wb_q;
  logic [PTR_W-1:0] ptr_q  [CH];
  // Length and xD are kept per bank so a pending group keeps its own values
  // while the same channel starts its next group in the other bank.
  logic [CNT_W-1:0] len_q  [CH][2];
  logic [DW-1:0]    xd_q   [CH][2];
  logic [CH_W:0]    fifo_q [FD];
  logic [FP_W-1:0]  wr_q, rd_q;
  logic [FC_W-1:0]  cnt_q;
  logic             cfg_err_q;

  logic             ch_ok, cur_wb, grp_start, grp_last, cfg_bad;
  logic             accept, push, pop, head_bk;
  logic [PTR_W-1:0] cur_ptr;
  logic [CNT_W-1:0] len_new, cur_len;
  logic [CH_W-1:0]  head_ch;

  // Channel ids beyond CH-1 only exist when CH is not a power of two.
  if (CH == (1 << CH_W)) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    assign ch_ok = (tile_ch_i < CH_W'(CH));
  end

  assign cur_wb       = wb_q[tile_ch_i];
  assign cur_ptr      = ptr_q[tile_ch_i];
  assign grp_start    = (cur_ptr == '0);
  assign cfg_bad      = (cfg_tiles_i == '0) || (cfg_tiles_i > CNT_W'(MAX_TILES));
  assign len_new      = cfg_bad ? CNT_W'(MAX_TILES) : cfg_tiles_i;
  assign cur_len      = grp_start ? len_new : len_q[tile_ch_i][cur_wb];
  assign grp_last     = ((CNT_W'(cur_ptr) + CNT_W'(1)) == cur_len);
  assign tile_ready_o = ch_ok ? !full_q[tile_ch_i][cur_wb] : 1'b1;
  assign accept       = tile_valid_i && tile_ready_o && ch_ok;
  assign push         = accept && grp_last;
  assign grp_valid_o  = (cnt_q != '0);
  assign pop          = grp_valid_o && grp_ready_i;
  assign {head_ch, head_bk} = fifo_q[rd_q];
  assign cfg_err_o    = cfg_err_q;

  function automatic logic [FP_W-1:0] fifo_inc(input logic [FP_W-1:0] p);
    return (p == FP_W'(FD - 1)) ? '0 : p + FP_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < CH; c++) begin
        full_q[c] <= '0;
        ptr_q[c]  <= '0;
        for (int b = 0; b < 2; b++) begin
          len_q[c][b] <= '0;
          xd_q[c][b]  <= '0;
        end
      end
      for (int i = 0; i < FD; i++) fifo_q[i] <= '0;
      wb_q      <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      cfg_err_q <= 1'b0;
    end else begin
      // The popped bank is always full, the written bank never is, so these
      // two full-flag updates never target the same bit.
      if (pop) full_q[head_ch][head_bk] <= 1'b0;
      if (accept) begin
        if (grp_start) begin
          len_q[tile_ch_i][cur_wb] <= len_new;
          xd_q[tile_ch_i][cur_wb]  <= xD_i;
          if (cfg_bad) cfg_err_q <= 1'b1;
        end
        if (grp_last) begin
          full_q[tile_ch_i][cur_wb] <= 1'b1;
          fifo_q[wr_q]              <= {tile_ch_i, cur_wb};
          ptr_q[tile_ch_i]          <= '0;
          wb_q[tile_ch_i]           <= !cur_wb;
        end else begin
          ptr_q[tile_ch_i] <= cur_ptr + PTR_W'(1);
        end
      end
      if (push) wr_q <= fifo_inc(wr_q);
      if (pop)  rd_q <= fifo_inc(rd_q);
      cnt_q <= cnt_q + FC_W'(push) - FC_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      for (int k = 0; k < MAX_TILES; k++) begin
        if (PTR_W'(k) == cur_ptr)
          mem_q[tile_ch_i][cur_wb][k] <= tile_data_i;
        else if (grp_start && (CNT_W'(k) >= len_new))
          mem_q[tile_ch_i][cur_wb][k] <= '0;
      end
    end
  end

  always_comb begin
    grp_ch_o     = '0;
    grp_data_o   = '0;
    grp_xD_o     = '0;
    grp_ntiles_o = '0;
    if (grp_valid_o) begin
      grp_ch_o     = head_ch;
      grp_xD_o     = xd_q[head_ch][head_bk];
      grp_ntiles_o = len_q[head_ch][head_bk];
      for (int k = 0; k < MAX_TILES; k++)
        grp_data_o[k*TW +: TW] = mem_q[head_ch][head_bk][k];
    end
  end

endmodule

// File: tb/tb_ssm_tile_gather.sv
// tb/tb_ssm_tile_gather.sv - scoreboard bench for ssm_tile_gather
module tb_ssm_tile_gather;

  localparam int DW        = 16;
  localparam int N_TILE    = 16;
  localparam int MAX_TILES = 8;
  localparam int CH        = 4;
  localparam int CH_W      = 2;
  localparam int CNT_W     = 4;
  localparam int TW        = N_TILE * DW;
  localparam int GW        = MAX_TILES * TW;
  localparam int SW        = 1 + CH_W + DW + CNT_W + GW;

  logic             clk = 1'b0;
  logic             rstn;
  logic [CNT_W-1:0] cfg_tiles_i;
  logic             tile_valid_i;
  logic             tile_ready_o;
  logic [CH_W-1:0]  tile_ch_i;
  logic [TW-1:0]    tile_data_i;
  logic [DW-1:0]    xD_i;
  logic             grp_valid_o;
  logic             grp_ready_i;
  logic [CH_W-1:0]  grp_ch_o;
  logic [GW-1:0]    grp_data_o;
  logic [DW-1:0]    grp_xD_o;
  logic [CNT_W-1:0] grp_ntiles_o;
  logic             cfg_err_o;

  ssm_tile_gather #(
    .DW(DW), .N_TILE(N_TILE), .MAX_TILES(MAX_TILES), .CH(CH), .CH_W(CH_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rstn(rstn), .cfg_tiles_i(cfg_tiles_i),
    .tile_valid_i(tile_valid_i), .tile_ready_o(tile_ready_o), .tile_ch_i(tile_ch_i),
    .tile_data_i(tile_data_i), .xD_i(xD_i),
    .grp_valid_o(grp_valid_o), .grp_ready_i(grp_ready_i), .grp_ch_o(grp_ch_o),
    .grp_data_o(grp_data_o), .grp_xD_o(grp_xD_o), .grp_ntiles_o(grp_ntiles_o),
    .cfg_err_o(cfg_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH_W-1:0]  ch;
    logic [CNT_W-1:0] n;
    logic [DW-1:0]    xd;
    logic [GW-1:0]    data;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] vals [MAX_TILES];
  logic [SW-1:0] cap;
  int            n_cmp = 0;
  int            n_bad = 0;

  function automatic logic [TW-1:0] mk_tile(input logic [DW-1:0] v);
    logic [TW-1:0] r;
    for (int i = 0; i < N_TILE; i++) r[i*DW +: DW] = v ^ DW'(i);
    return r;
  endfunction

  function automatic logic [SW-1:0] snap();
    return {grp_valid_o, grp_ch_o, grp_xD_o, grp_ntiles_o, grp_data_o};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input int ch, input int n, input logic [DW-1:0] xd);
    exp_t e;
    e.ch   = CH_W'(ch);
    e.n    = CNT_W'(n);
    e.xd   = xd;
    e.data = '0;
    for (int k = 0; k < n; k++) e.data[k*TW +: TW] = mk_tile(vals[k]);
    exp_q.push_back(e);
  endtask

  task automatic send_tile(input int ch, input int cfg, input logic [DW-1:0] v,
                           input logic [DW-1:0] xd);
    int w;
    w            = 0;
    tile_valid_i = 1'b1;
    tile_ch_i    = CH_W'(ch);
    cfg_tiles_i  = CNT_W'(cfg);
    tile_data_i  = mk_tile(v);
    xD_i         = xd;
    @(negedge clk);
    while (!tile_ready_o && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (!tile_ready_o) begin
      n_cmp++;
      n_bad++;
      $display("FAIL tile_accept_timeout ch=%0d act ready=0 exp ready=1", ch);
    end
    @(posedge clk);
    #1;
    tile_valid_i = 1'b0;
  endtask

  task automatic send_vals(input int ch, input int n, input int cfg0, input int cfgr,
                           input logic [DW-1:0] xd0);
    for (int k = 0; k < n; k++)
      send_tile(ch, (k == 0) ? cfg0 : cfgr, vals[k], (k == 0) ? xd0 : 16'hFFFF);
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while (exp_q.size() != 0 && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout act pending=%0d exp pending=0", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset();
    chk("rst_tile_ready", 64'(tile_ready_o), 64'd1);
    chk("rst_grp_valid", 64'(grp_valid_o), 64'd0);
    chk("rst_grp_ch", 64'(grp_ch_o), 64'd0);
    chk("rst_grp_xD", 64'(grp_xD_o), 64'd0);
    chk("rst_grp_ntiles", 64'(grp_ntiles_o), 64'd0);
    chk("rst_cfg_err", 64'(cfg_err_o), 64'd0);
    n_cmp++;
    if (grp_data_o !== '0) begin
      n_bad++;
      $display("FAIL rst_grp_data act low=%h exp 0", grp_data_o[63:0]);
    end
  endtask

  // Monitor: every handshake is checked against the oldest expected group.
  initial begin
    exp_t e;
    bit   shown;
    forever begin
      @(negedge clk);
      if (grp_valid_o && grp_ready_i) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL grp_unexpected act ch=%0d exp none", grp_ch_o);
        end else begin
          e = exp_q.pop_front();
          chk("grp_ch", 64'(grp_ch_o), 64'(e.ch));
          chk("grp_ntiles", 64'(grp_ntiles_o), 64'(e.n));
          chk("grp_xD", 64'(grp_xD_o), 64'(e.xd));
          n_cmp++;
          if (grp_data_o !== e.data) begin
            n_bad++;
            shown = 1'b0;
            for (int k = 0; k < MAX_TILES; k++) begin
              if (!shown && grp_data_o[k*TW +: TW] !== e.data[k*TW +: TW]) begin
                $display("FAIL grp_data ch=%0d slot %0d act=%h exp=%h", e.ch, k,
                         grp_data_o[k*TW +: TW], e.data[k*TW +: TW]);
                shown = 1'b1;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn         = 1'b0;
    cfg_tiles_i  = '0;
    tile_valid_i = 1'b0;
    tile_ch_i    = '0;
    tile_data_i  = '0;
    xD_i         = '0;
    grp_ready_i  = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_reset();
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Full 8-tile group, xD taken from tile 0 only, one-cycle latency.
    vals = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400, 16'h4500, 16'h4600, 16'h4700, 16'h4800};
    push_exp(0, 8, 16'h3800);
    for (int k = 0; k < 7; k++) send_tile(0, 8, vals[k], (k == 0) ? 16'h3800 : 16'hFFFF);
    chk("t1_valid_before_last", 64'(grp_valid_o), 64'd0);
    send_tile(0, 8, vals[7], 16'hFFFF);
    chk("t1_valid_latency", 64'(grp_valid_o), 64'd1);

    // Group of 3 with cfg changing mid-group, then a group of 5 in the
    // bank that held 8 tiles: slots 5..7 must come back zero.
    vals = '{16'h1111, 16'h2222, 16'h3333, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(0, 3, 16'h1234);
    send_tile(0, 3, vals[0], 16'h1234);
    send_tile(0, 5, vals[1], 16'hFFFF);
    send_tile(0, 5, vals[2], 16'hFFFF);
    vals = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005, 16'h0, 16'h0, 16'h0};
    push_exp(0, 5, 16'h5678);
    send_vals(0, 5, 5, 5, 16'h5678);
    wait_drain();

    // Backpressure on channel 2 only.
    grp_ready_i = 1'b0;
    vals = '{16'h2001, 16'h2002, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(2, 2, 16'h2A00);
    send_vals(2, 2, 2, 2, 16'h2A00);
    vals = '{16'h2011, 16'h2012, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(2, 2, 16'h2B00);
    send_vals(2, 2, 2, 2, 16'h2B00);
    tile_valid_i = 1'b1;
    tile_ch_i    = 2'd2;
    cfg_tiles_i  = 4'd2;
    tile_data_i  = mk_tile(16'h2021);
    xD_i         = 16'h2C00;
    #1;
    chk("t3_ch2_blocked", 64'(tile_ready_o), 64'd0);
    tile_ch_i   = 2'd0;
    tile_data_i = mk_tile(16'h0A01);
    xD_i        = 16'h0A0A;
    #1;
    chk("t3_ch0_open", 64'(tile_ready_o), 64'd1);
    @(posedge clk);
    #1;
    tile_valid_i = 1'b0;
    tile_ch_i    = 2'd2;
    grp_ready_i  = 1'b1;
    #1;
    chk("t3_ch2_blocked_in_hs_cycle", 64'(tile_ready_o), 64'd0);
    @(posedge clk);
    #1;
    grp_ready_i = 1'b0;
    chk("t3_ch2_ready_back", 64'(tile_ready_o), 64'd1);
    vals = '{16'h2021, 16'h2022, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(2, 2, 16'h2C00);
    send_vals(2, 2, 2, 2, 16'h2C00);
    vals = '{16'h0A01, 16'h0A02, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(0, 2, 16'h0A0A);
    send_tile(0, 7, vals[1], 16'hFFFF);
    grp_ready_i = 1'b1;
    wait_drain();

    // Interleaved channels: completion order ch1 then ch0, stable under stall.
    grp_ready_i = 1'b0;
    vals = '{16'h1101, 16'h1102, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(1, 2, 16'h1A00);
    vals = '{16'h0B01, 16'h0B02, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
    push_exp(0, 2, 16'h0B0B);
    send_tile(1, 2, 16'h1101, 16'h1A00);
    send_tile(0, 2, 16'h0B01, 16'h0B0B);
    send_tile(1, 2, 16'h1102, 16'hFFFF);
    send_tile(0, 2, 16'h0B02, 16'hFFFF);
    @(negedge clk);
    chk("t4_head_ch", 64'(grp_ch_o), 64'd1);
    cap = snap();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (snap() !== cap) begin
        n_bad++;
        $display("FAIL t4_stable cycle %0d act ch=%0d n=%0d exp ch=%0d n=%0d", c,
                 grp_ch_o, grp_ntiles_o, cap[GW+CNT_W+DW +: CH_W], cap[GW +: CNT_W]);
      end
    end
    @(posedge clk);
    #1;
    grp_ready_i = 1'b1;
    wait_drain();

    // Illegal cfg values clamp to MAX_TILES and set the sticky flag.
    chk("t5_err_before", 64'(cfg_err_o), 64'd0);
    vals = '{16'h5001, 16'h5002, 16'h5003, 16'h5004, 16'h5005, 16'h5006, 16'h5007, 16'h5008};
    push_exp(3, 8, 16'h5A00);
    send_tile(3, 0, vals[0], 16'h5A00);
    chk("t5_err_after_zero", 64'(cfg_err_o), 64'd1);
    for (int k = 1; k < 8; k++) send_tile(3, 0, vals[k], 16'hFFFF);
    vals = '{16'h6001, 16'h6002, 16'h6003, 16'h6004, 16'h6005, 16'h6006, 16'h6007, 16'h6008};
    push_exp(3, 8, 16'h6A00);
    send_vals(3, 8, 9, 9, 16'h6A00);
    chk("t5_err_sticky", 64'(cfg_err_o), 64'd1);
    wait_drain();

    // Reset with a pending group and a partial group: both discarded.
    grp_ready_i = 1'b0;
    send_tile(0, 2, 16'h0C01, 16'h0C0C);
    send_tile(0, 2, 16'h0C02, 16'hFFFF);
    for (int k = 0; k < 5; k++) send_tile(1, 8, 16'(16'hEE00 + k), 16'hEEEE);
    chk("t6_pending_valid", 64'(grp_valid_o), 64'd1);
    rstn = 1'b0;
    #1;
    chk_reset();
    @(posedge clk);
    #1;
    rstn        = 1'b1;
    grp_ready_i = 1'b1;
    vals = '{16'h7001, 16'h7002, 16'h7003, 16'h7004, 16'h7005, 16'h7006, 16'h7007, 16'h7008};
    push_exp(1, 8, 16'h7A00);
    send_vals(1, 8, 8, 8, 16'h7A00);
    wait_drain();
    repeat (3) @(posedge clk);
    #1;
    chk("final_grp_valid", 64'(grp_valid_o), 64'd0);
    chk("final_scoreboard_left", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
